// File: rtl/pwm_intb_pkg.sv
// rtl/pwm_intb_pkg.sv - shared PWM/INTB link constants, watchdog tables and decode state type
//
// Purpose: single source for the bit-window length and watchdog periods used by
// both the HV encoder and the LV decoder, so both ends of the link agree.
// Ports: none (package).
package pwm_intb_pkg;

   // Cycles per encoded bit window on the shared PWM/INTB line.
   localparam int unsigned PWM_INTB_EXT_CYC_NUM = 8;

   // Nominal interrupt-frame period selectable by a 2-bit config.
   localparam int unsigned WDG_INTB_TH [4] = '{40, 64, 128, 256};

   // Frame timeout is twice the nominal period, so one lost frame is tolerated.
   localparam int unsigned WDG_TO_TH [4] = '{
      2 * WDG_INTB_TH[0],
      2 * WDG_INTB_TH[1],
      2 * WDG_INTB_TH[2],
      2 * WDG_INTB_TH[3]
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BIT0 = 2'd1,
      ST_BIT1 = 2'd2,
      ST_BIT2 = 2'd3
   } dec_state_e;

endpackage

// File: rtl/pwm_intb_win_cnt.sv
// rtl/pwm_intb_win_cnt.sv - bit-window counter with majority tally of mismatch cycles
//
// Purpose: counts window cycles 0..N-1 while run is high and tallies mis=1 cycles
// inside the current window; both clear at every window boundary and whenever
// run is low.
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   run       in   window counting enabled this cycle (this cycle is a window cycle)
//   mis       in   line/reference mismatch this cycle
//   win_end   out  this cycle is the last cycle (N-1) of a window
//   win_major out  tally including this cycle reaches N/2+1 (meaningful with win_end)
module pwm_intb_win_cnt #(
   parameter int unsigned N = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic mis,
   output logic win_end,
   output logic win_major
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned TW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [TW:0]   MAJ  = (TW + 1)'(N / 2 + 1);

   logic [CW-1:0] cnt_q;
   logic [TW-1:0] tally_q;
   logic [TW:0]   tally_now;

   // The current cycle's mismatch is folded in combinationally so the
   // decision at the window end covers all N cycles without an extra stage.
   assign tally_now = {1'b0, tally_q} + {{TW{1'b0}}, mis};
   assign win_end   = run && (cnt_q == LAST);
   assign win_major = (tally_now >= MAJ);

   always_ff @(posedge clk) begin
      if (!rst_n || !run || win_end) begin
         cnt_q   <= '0;
         tally_q <= '0;
      end else begin
         cnt_q   <= cnt_q + CW'(1);
         tally_q <= tally_now[TW-1:0];
      end
   end

endmodule

// File: rtl/lv_pwm_intb_decode.sv
// rtl/lv_pwm_intb_decode.sv - LV-side decoder of HV interrupt frames on the shared PWM/INTB line
//
// Purpose: compares the received line against the locally launched PWM wave
// (delayed by the link round trip), detects 3-window frames BIT0/BIT1/BIT2,
// reports the decoded interrupt level and supervises frame arrival.
// Ports:
//   i_clk          in   clock
//   i_rst_n        in   synchronous active-low reset
//   i_pwm_intb_n   in   received shared line, synchronised to i_clk
//   i_lv_pwm_ref   in   local PWM gate wave as launched toward HV
//   i_wdg_chk_en   in   frame-timeout supervision enable
//   i_wdg_to_cfg   in   timeout threshold table index
//   o_intb_n       out  decoded HV interrupt level, active-low
//   o_frame_vld    out  one-cycle pulse per decoded frame
//   o_frame_type   out  decoded frame type (1 = INTB1, 0 = INTB0), valid with o_frame_vld
//   o_glitch       out  one-cycle pulse when a BIT0 window is rejected
//   o_wdg_timeout  out  sticky: no frame within the selected threshold
module lv_pwm_intb_decode #(
   parameter int unsigned PWM_INTB_EXT_CYC_NUM = pwm_intb_pkg::PWM_INTB_EXT_CYC_NUM,
   parameter int unsigned LINK_DLY_CYC         = 3,
   parameter int unsigned WDG_CNT_W            = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_pwm_intb_n,
   input  logic       i_lv_pwm_ref,
   input  logic       i_wdg_chk_en,
   input  logic [1:0] i_wdg_to_cfg,
   output logic       o_intb_n,
   output logic       o_frame_vld,
   output logic       o_frame_type,
   output logic       o_glitch,
   output logic       o_wdg_timeout
);

   import pwm_intb_pkg::*;

   // ---------------------------------------------------------------
   // Reference alignment and mismatch detection
   // ---------------------------------------------------------------
   logic [LINK_DLY_CYC-1:0] dly_q;
   logic                    ref_dly;
   logic                    mis;

   assign ref_dly = dly_q[LINK_DLY_CYC-1];
   assign mis     = i_pwm_intb_n ^ ref_dly;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         dly_q <= '0;
      end else begin
         dly_q[0] <= i_lv_pwm_ref;
         for (int i = 1; i < int'(LINK_DLY_CYC); i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end
   end

   // ---------------------------------------------------------------
   // Window counter / majority tally
   // ---------------------------------------------------------------
   dec_state_e state_q;
   dec_state_e state_d;
   logic       run;
   logic       win_end;
   logic       win_major;

   // The first mismatching cycle in IDLE already counts as window cycle 0.
   assign run = (state_q != ST_IDLE) || mis;

   pwm_intb_win_cnt #(
      .N (PWM_INTB_EXT_CYC_NUM)
   ) u_win_cnt (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .run       (run),
      .mis       (mis),
      .win_end   (win_end),
      .win_major (win_major)
   );

   // ---------------------------------------------------------------
   // Decode FSM
   // ---------------------------------------------------------------
   logic glitch_d;
   logic dec_vld_d;
   logic dec_type_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      glitch_d   = 1'b0;
      dec_vld_d  = 1'b0;
      dec_type_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mis) begin
               state_d = ST_BIT0;
            end
         end
         ST_BIT0: begin
            if (win_end) begin
               if (win_major) begin
                  state_d = ST_BIT1;
               end else begin
                  state_d  = ST_IDLE;
                  glitch_d = 1'b1;
               end
            end
         end
         // BIT1 carries the locked gate wave; only its length matters.
         ST_BIT1: begin
            if (win_end) begin
               state_d = ST_BIT2;
            end
         end
         ST_BIT2: begin
            if (win_end) begin
               state_d    = ST_IDLE;
               dec_vld_d  = 1'b1;
               dec_type_d = win_major;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Output stage. The decode result passes through one staging flop so
   // that o_frame_vld lands 3N+1 cycles after the first mismatching cycle;
   // the glitch pulse is reported directly from the BIT0 decision.
   // ---------------------------------------------------------------
   logic dec_vld_q;
   logic dec_type_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         dec_vld_q    <= 1'b0;
         dec_type_q   <= 1'b0;
         o_glitch     <= 1'b0;
         o_frame_vld  <= 1'b0;
         o_frame_type <= 1'b0;
         o_intb_n     <= 1'b1;
      end else begin
         dec_vld_q   <= dec_vld_d;
         dec_type_q  <= dec_type_d;
         o_glitch    <= glitch_d;
         o_frame_vld <= dec_vld_q;
         if (dec_vld_q) begin
            o_frame_type <= dec_type_q;
            o_intb_n     <= dec_type_q;
         end
      end
   end

   // ---------------------------------------------------------------
   // Frame watchdog. Equality against threshold-1 means a counter already
   // past a newly lowered threshold just runs on to saturation silently.
   // ---------------------------------------------------------------
   logic [WDG_CNT_W-1:0] wdg_cnt_q;
   logic [WDG_CNT_W-1:0] wdg_th_m1;

   assign wdg_th_m1 = WDG_CNT_W'(WDG_TO_TH[i_wdg_to_cfg] - 1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wdg_cnt_q     <= '0;
         o_wdg_timeout <= 1'b0;
      end else if (o_frame_vld || !i_wdg_chk_en) begin
         // A frame in the threshold cycle wins over the timeout.
         wdg_cnt_q     <= '0;
         o_wdg_timeout <= 1'b0;
      end else begin
         if (wdg_cnt_q != '1) begin
            wdg_cnt_q <= wdg_cnt_q + WDG_CNT_W'(1);
         end
         if (wdg_cnt_q == wdg_th_m1) begin
            o_wdg_timeout <= 1'b1;
         end
      end
   end

endmodule
